iob_master: RTL and testbench
=============================

IOB_MASTER -- requirements
Module: iob_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max CLK cycles in WAIT/VPA before forced bus-error termination.
REQ-002 Parameter RECOVER, default 2: min CLK cycles nAS held high between consecutive bus cycles.
REQ-003 CLK  in  1  single clock for all logic.
REQ-004 RST  in  1  synchronous active-high reset, sampled on rising CLK.
REQ-005 IOREQ  in  1  request from FSB-side posting block; asynchronous, 2-flop synchronized (IOREQs).
REQ-006 IORW0 / IOL0 / IOU0  in  1 each  direction (1=read), lower/upper byte select; stable while IOREQ=1.
REQ-007 IOACT  out  1  registered; acknowledge/busy to FSB side.
REQ-008 nDTACK / nVPA / nBERR  in  1 each  IOB bus terminations, active-low, async, 2-flop synchronized.
REQ-009 nAS / nLDS / nUDS  out  1 each  IOB strobes, active-low, registered.
REQ-010 IORW  out  1  IOB read/write, registered; nVMA  out  1  6800 valid memory address, active-low.
REQ-011 E  out  1  6800 E clock, registered; nDinLE  out  1  read-data latch enable, one-cycle low pulse.
REQ-012 IOBERR  out  1  set on BERR or timeout; valid while IOACT=1.

Function
REQ-013 The module SHALL use a 4-phase handshake: IOACT rises after IOREQs=1, falls only after IOREQs=0 and cycle complete.
REQ-014 E counter SHALL run free 0..9, wrapping 9->0; E=1 for counts 6..9, else 0 (6 low/4 high).
REQ-015 States SHALL be IDLE, S1, S2, S3, WAIT, VPA, S5, S6, S7, RCV, DONE.
REQ-016 IDLE: IOREQs=1 and RCV satisfied -> capture IORW0/IOL0/IOU0, IOACT<=1, IOBERR<=0, ->S1.
REQ-017 S1: drive IORW from captured value, ->S2.
REQ-018 S2: nAS<=0; read: nLDS/nUDS<=~IOL/~IOU in same edge; ->S3.
REQ-019 S3: write: nLDS/nUDS asserted this edge (one cycle after nAS); ->WAIT; timeout counter cleared.
REQ-020 WAIT, priority BERR > DTACK > VPA: sync nBERR=0 -> IOBERR<=1, ->S6; sync nDTACK=0 -> S5; sync nVPA=0 -> VPA.
REQ-021 VPA: at next E count 0, nVMA<=0; terminate at following 9->0 wrap (E falling), ->S6.
REQ-022 Timeout counter SHALL increment each WAIT/VPA cycle; at TIMEOUT-1 with no termination: IOBERR<=1, ->S6.
REQ-023 S5: one data-settle cycle, ->S6.
REQ-024 S6: read without IOBERR -> nDinLE=0 for exactly this cycle; ->S7.
REQ-025 S7: nAS, nLDS, nUDS, nVMA <=1 same edge; ->RCV.
REQ-026 RCV: hold RECOVER cycles with nAS=1, ->DONE.
REQ-027 DONE: IOREQs=0 -> IOACT<=0, ->IDLE; else hold IOACT=1.
REQ-028 New cycle SHALL NOT start until IOREQs seen 0 after previous IOACT (no double-issue on stale IOREQ).
REQ-029 Strobes SHALL never assert outside S2..S7; IORW SHALL not change while nAS=0.
REQ-030 BERR and DTACK same cycle -> BERR path; DTACK during VPA state -> ignored.

Reset
REQ-031 RST=1: state IDLE, E counter 0, E=0, IOACT=0, IOBERR=0, nAS=nLDS=nUDS=nVMA=nDinLE=1, IORW=1, sync flops cleared to inactive.
REQ-032 RST mid-cycle SHALL negate all strobes at the next edge; no nDinLE pulse emitted.

Verification
REQ-033 Read, IOL0=IOU0=1, nDTACK low 3 cycles after nAS -> nLDS/nUDS fall with nAS, single nDinLE pulse in S6, strobes high in S7, IOACT falls after IOREQ drops.
REQ-034 Write, IOL0=1 IOU0=0, DTACK -> nLDS falls one cycle after nAS, nUDS stays 1, no nDinLE pulse.
REQ-035 VPA read -> nVMA at E count 0, cycle ends on E 9->0 wrap after high phase, nDinLE pulses once.
REQ-036 No termination, TIMEOUT=16 -> IOBERR=1 after 16 WAIT cycles, strobes negate, no nDinLE.
REQ-037 IOREQ held high through DONE -> IOACT stays 1, no second nAS until IOREQ low then high again.
REQ-038 RST asserted in WAIT -> next edge all outputs at reset values, E counter 0.

Source files
------------

// File: rtl/iob_master.sv
// IOB bus master: turns a posted FSB request into one 68k-style IOB
// bus cycle (DTACK, 6800 VPA/E, BERR or timeout termination).
module iob_master #(
  parameter int TIMEOUT = 255,
  parameter int RECOVER = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic IOREQ,
  input  logic IORW0,
  input  logic IOL0,
  input  logic IOU0,
  output logic IOACT,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR,
  output logic nAS,
  output logic nLDS,
  output logic nUDS,
  output logic IORW,
  output logic nVMA,
  output logic E,
  output logic nDinLE,
  output logic IOBERR
);

  localparam int TO_N = (TIMEOUT < 1) ? 1 : TIMEOUT;
  localparam int TW   = $clog2(TO_N + 1);
  localparam int RC_N = (RECOVER < 1) ? 1 : RECOVER;
  localparam int RW   = $clog2(RC_N + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_N - 1);
  localparam logic [RW-1:0] RC_LAST = RW'(RC_N - 1);

  typedef enum logic [3:0] {
    IDLE, S1, S2, S3, WAIT, VPA, S5, S6, S7, RCV, DONE
  } state_t;

  state_t state_q, state_d;

  // sync bit order: {req, dtack, vpa, berr}, all active-high
  logic [3:0] meta_q, sync_q;
  logic       req_s, dtack_s, vpa_s, berr_s;

  logic [3:0]    ecnt_q, ecnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic rw_q, rw_d, lds_q, lds_d, uds_q, uds_d;
  logic e_q, e_d, ioact_q, ioact_d, ioberr_q, ioberr_d;
  logic nas_q, nas_d, nlds_q, nlds_d, nuds_q, nuds_d;
  logic iorw_q, iorw_d, nvma_q, nvma_d, ndinle_q, ndinle_d;

  assign req_s   = sync_q[3];
  assign dtack_s = sync_q[2];
  assign vpa_s   = sync_q[1];
  assign berr_s  = sync_q[0];

  always_comb begin
    state_d  = state_q;
    ecnt_d   = (ecnt_q == 4'd9) ? 4'd0 : ecnt_q + 4'd1;
    tcnt_d   = tcnt_q;
    rcnt_d   = rcnt_q;
    rw_d     = rw_q;
    lds_d    = lds_q;
    uds_d    = uds_q;
    ioact_d  = ioact_q;
    ioberr_d = ioberr_q;
    nas_d    = nas_q;
    nlds_d   = nlds_q;
    nuds_d   = nuds_q;
    iorw_d   = iorw_q;
    nvma_d   = nvma_q;
    ndinle_d = 1'b1;
    unique case (state_q)
      IDLE: if (req_s) begin
        rw_d     = IORW0;
        lds_d    = IOL0;
        uds_d    = IOU0;
        ioact_d  = 1'b1;
        ioberr_d = 1'b0;
        state_d  = S1;
      end
      S1: begin
        iorw_d  = rw_q;
        state_d = S2;
      end
      S2: begin
        nas_d = 1'b0;
        if (rw_q) begin
          nlds_d = ~lds_q;
          nuds_d = ~uds_q;
        end
        state_d = S3;
      end
      S3: begin
        if (!rw_q) begin
          nlds_d = ~lds_q;
          nuds_d = ~uds_q;
        end
        tcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        if (berr_s) begin
          ioberr_d = 1'b1;
          state_d  = S6;
        end else if (dtack_s) begin
          state_d = S5;
        end else if (vpa_s) begin
          state_d = VPA;
        end else if (tcnt_q >= TO_LAST) begin
          ioberr_d = 1'b1;
          state_d  = S6;
        end
      end
      VPA: begin
        tcnt_d = tcnt_q + TW'(1);
        if (berr_s) begin
          ioberr_d = 1'b1;
          state_d  = S6;
        end else if (ecnt_q == 4'd9 && !nvma_q) begin
          state_d = S6;
        end else if (tcnt_q >= TO_LAST) begin
          ioberr_d = 1'b1;
          state_d  = S6;
        end else if (ecnt_q == 4'd9) begin
          nvma_d = 1'b0;
        end
      end
      S5: state_d = S6;
      S6: state_d = S7;
      S7: begin
        nas_d   = 1'b1;
        nlds_d  = 1'b1;
        nuds_d  = 1'b1;
        nvma_d  = 1'b1;
        rcnt_d  = '0;
        state_d = RCV;
      end
      RCV: begin
        rcnt_d = rcnt_q + RW'(1);
        if (rcnt_q == RC_LAST) begin
          iorw_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (!req_s) begin
        ioact_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == S6 && state_q != S6 && rw_q && !ioberr_d)
      ndinle_d = 1'b0;
    e_d = (ecnt_d >= 4'd6);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      meta_q   <= '0;
      sync_q   <= '0;
      ecnt_q   <= '0;
      tcnt_q   <= '0;
      rcnt_q   <= '0;
      rw_q     <= 1'b1;
      lds_q    <= 1'b0;
      uds_q    <= 1'b0;
      e_q      <= 1'b0;
      ioact_q  <= 1'b0;
      ioberr_q <= 1'b0;
      nas_q    <= 1'b1;
      nlds_q   <= 1'b1;
      nuds_q   <= 1'b1;
      iorw_q   <= 1'b1;
      nvma_q   <= 1'b1;
      ndinle_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      meta_q   <= {IOREQ, ~nDTACK, ~nVPA, ~nBERR};
      sync_q   <= meta_q;
      ecnt_q   <= ecnt_d;
      tcnt_q   <= tcnt_d;
      rcnt_q   <= rcnt_d;
      rw_q     <= rw_d;
      lds_q    <= lds_d;
      uds_q    <= uds_d;
      e_q      <= e_d;
      ioact_q  <= ioact_d;
      ioberr_q <= ioberr_d;
      nas_q    <= nas_d;
      nlds_q   <= nlds_d;
      nuds_q   <= nuds_d;
      iorw_q   <= iorw_d;
      nvma_q   <= nvma_d;
      ndinle_q <= ndinle_d;
    end
  end

  assign IOACT  = ioact_q;
  assign IOBERR = ioberr_q;
  assign nAS    = nas_q;
  assign nLDS   = nlds_q;
  assign nUDS   = nuds_q;
  assign IORW   = iorw_q;
  assign nVMA   = nvma_q;
  assign E      = e_q;
  assign nDinLE = ndinle_q;

endmodule

// File: tb/tb_iob_master.sv
// Bench for iob_master: bus responder, per-cycle monitor with
// expected-record queue, plus reset and E-clock checks.
module tb_iob_master;

  logic CLK = 1'b0;
  logic RST, IOREQ, IORW0, IOL0, IOU0;
  logic nDTACK, nVPA, nBERR;
  logic IOACT, nAS, nLDS, nUDS, IORW, nVMA, E, nDinLE, IOBERR;

  always #5 CLK = ~CLK;

  iob_master #(.TIMEOUT(16), .RECOVER(2)) dut (
    .CLK(CLK), .RST(RST), .IOREQ(IOREQ),
    .IORW0(IORW0), .IOL0(IOL0), .IOU0(IOU0),
    .IOACT(IOACT), .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR),
    .nAS(nAS), .nLDS(nLDS), .nUDS(nUDS), .IORW(IORW),
    .nVMA(nVMA), .E(E), .nDinLE(nDinLE), .IOBERR(IOBERR)
  );

  typedef struct {
    int rw; int lds; int uds; int dinle; int berr;
    int bdly; int vma; int vok; int def; int rwchg;
  } rec_t;

  rec_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int mode = 0;
  int nas_falls = 0;
  localparam int NEVER = 99;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic rec_t mk(input int rw, input int lds, input int uds,
                              input int dinle, input int berr, input int bdly,
                              input int vma, input int vok, input int def);
    rec_t r;
    r.rw = rw; r.lds = lds; r.uds = uds; r.dinle = dinle; r.berr = berr;
    r.bdly = bdly; r.vma = vma; r.vok = vok; r.def = def; r.rwchg = 0;
    return r;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cmp_rec(input rec_t o, input rec_t e);
    chk("iorw", o.rw, e.rw);
    chk("nlds_delay", o.lds, e.lds);
    chk("nuds_delay", o.uds, e.uds);
    chk("ndinle_pulses", o.dinle, e.dinle);
    chk("ioberr", o.berr, e.berr);
    chk("ioberr_delay", o.bdly, e.bdly);
    chk("nvma_seen", o.vma, e.vma);
    chk("nvma_at_e0", o.vok, e.vok);
    chk("ndinle_at_efall", o.def, e.def);
    chk("iorw_stable", o.rwchg, e.rwchg);
  endtask

  // Responder: mode 1 DTACK 3 cycles after nAS, 2 VPA (+late DTACK),
  // 3 BERR and DTACK together, 0 never terminates.
  initial begin
    int cnt;
    cnt = -1;
    nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
    forever begin
      step();
      if (nAS === 1'b1) begin
        cnt = -1;
        nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
      end else if (nAS === 1'b0) begin
        cnt++;
        case (mode)
          1: if (cnt == 3) nDTACK = 1'b0;
          2: begin
            if (cnt == 0) nVPA = 1'b0;
            if (cnt == 5) nDTACK = 1'b0;
          end
          3: if (cnt == 0) begin nBERR = 1'b0; nDTACK = 1'b0; end
          default: ;
        endcase
      end
    end
  end

  // Monitor: builds one record per nAS low period, compares on nAS rise.
  initial begin
    int cyc, st;
    bit act, abort;
    logic pe, pas, plds, puds, pvma, pberr;
    rec_t ob, ex;
    cyc = 0; st = 0; act = 0; abort = 0;
    pe = 0; pas = 1; plds = 1; puds = 1; pvma = 1; pberr = 0;
    ob = mk(0, NEVER, NEVER, 0, 0, 0, 0, 0, 0);
    forever begin
      @(negedge CLK);
      cyc++;
      if (pas === 1'b1 && nAS === 1'b0) begin
        nas_falls++;
        act = 1; abort = 0; st = cyc;
        ob = mk(int'(IORW), NEVER, NEVER, 0, 0, 0, 0, 0, 0);
      end
      if (act) begin
        if (RST) abort = 1;
        if (plds && !nLDS && ob.lds == NEVER) ob.lds = cyc - st;
        if (puds && !nUDS && ob.uds == NEVER) ob.uds = cyc - st;
        if (pvma && !nVMA) begin
          ob.vma = 1;
          ob.vok = int'(pe && !E);
        end
        if (!nDinLE) begin
          ob.dinle++;
          if (ob.vma == 1 && pe && !E) ob.def = 1;
        end
        if (!pberr && IOBERR) ob.bdly = cyc - st;
        if (!nAS && int'(IORW) != ob.rw) ob.rwchg = 1;
        if (!pas && nAS) begin
          act = 0;
          ob.berr = int'(IOBERR);
          if (!abort) begin
            if (exp_q.size() == 0) begin
              bound_fail("unexpected_bus_cycle");
            end else begin
              ex = exp_q.pop_front();
              cmp_rec(ob, ex);
            end
          end
        end
      end
      pe = E; pas = nAS; plds = nLDS; puds = nUDS; pvma = nVMA;
      pberr = IOBERR;
    end
  end

  task automatic do_cycle(input bit rw, input bit l, input bit u,
                          input int m, input rec_t e, input int hold);
    int k, n0;
    logic pe;
    IORW0 = rw; IOL0 = l; IOU0 = u; mode = m;
    exp_q.push_back(e);
    if (m == 2) begin
      pe = E;
      step();
      k = 0;
      while (!(pe === 1'b1 && E === 1'b0) && k < 40) begin
        pe = E;
        step();
        k++;
      end
      if (k >= 40) bound_fail("e_fall_wait");
    end
    IOREQ = 1'b1;
    k = 0;
    while (IOACT !== 1'b1 && k < 20) begin step(); k++; end
    chk("ioact_rise_latency", k, 3);
    k = 0;
    while (nAS !== 1'b0 && k < 50) begin step(); k++; end
    if (k >= 50) bound_fail("nas_fall_wait");
    k = 0;
    while (nAS !== 1'b1 && k < 100) begin step(); k++; end
    if (k >= 100) bound_fail("nas_rise_wait");
    n0 = nas_falls;
    repeat (hold) step();
    chk("ioact_held", int'(IOACT), 1);
    if (hold > 10) chk("no_reissue_nas", nas_falls, n0);
    IOREQ = 1'b0;
    k = 0;
    while (IOACT !== 1'b0 && k < 20) begin step(); k++; end
    chk("ioact_fall_latency", k, 3);
    mode = 0;
    repeat (3) step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; IOREQ = 1'b0; IORW0 = 1'b1; IOL0 = 1'b0; IOU0 = 1'b0;
    repeat (3) step();
    chk("reset_outputs",
        int'({IOACT, IOBERR, nAS, nLDS, nUDS, nVMA, nDinLE, IORW, E}),
        int'(9'b001111110));
    RST = 1'b0;
    step();

    do_cycle(1, 1, 1, 1, mk(1, 0, 0, 1, 0, 0, 0, 0, 0), 4);
    do_cycle(0, 1, 0, 1, mk(0, 1, NEVER, 0, 0, 0, 0, 0, 0), 4);
    do_cycle(1, 1, 1, 2, mk(1, 0, 0, 1, 0, 0, 1, 1, 1), 4);
    do_cycle(1, 1, 1, 0, mk(1, 0, 0, 0, 1, 17, 0, 0, 0), 4);
    do_cycle(1, 0, 1, 3, mk(1, NEVER, 0, 0, 1, 3, 0, 0, 0), 4);
    do_cycle(0, 0, 1, 1, mk(0, NEVER, 1, 0, 0, 0, 0, 0, 0), 30);
    do_cycle(1, 1, 0, 1, mk(1, 0, NEVER, 1, 0, 0, 0, 0, 0), 4);

    // Reset while the bus cycle is waiting for a termination.
    begin
      int k;
      mode = 0; IORW0 = 1'b1; IOL0 = 1'b1; IOU0 = 1'b1;
      IOREQ = 1'b1;
      k = 0;
      while (nAS !== 1'b0 && k < 50) begin step(); k++; end
      if (k >= 50) bound_fail("rst_nas_wait");
      repeat (3) step();
      RST = 1'b1;
      IOREQ = 1'b0;
      step();
      chk("mid_reset_outputs",
          int'({IOACT, IOBERR, nAS, nLDS, nUDS, nVMA, nDinLE, IORW, E}),
          int'(9'b001111110));
      RST = 1'b0;
      for (int i = 1; i <= 10; i++) begin
        step();
        chk("e_phase_after_reset", int'(E), int'(i >= 6 && i <= 9));
      end
      chk("ioact_idle_after_reset", int'(IOACT), 0);
    end

    repeat (5) step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
